// File: rtl/vend_fsm_param_pkg.sv
// Shared types for the vending controller: coin codes and FSM state encoding.
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_NONE = 2'b00,
      COIN_A    = 2'b01,
      COIN_B    = 2'b10,
      COIN_C    = 2'b11
   } coin_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      VEND   = 2'd2,
      REFUND = 2'd3
   } vend_state_t;

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin/refund inputs and vend/change/debug outputs of the vending controller.
interface vend_fsm_param_if #(
   parameter int CREDIT_W = 4
);
   logic [1:0]          coin;
   logic                refund_req;
   logic                drop;
   logic [CREDIT_W-1:0] credit;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                coin_reject;
   logic [1:0]          state;

   modport master (
      output coin, refund_req,
      input  drop, credit, change_valid, change_amt, coin_reject, state
   );

   modport slave (
      input  coin, refund_req,
      output drop, credit, change_valid, change_amt, coin_reject, state
   );
endinterface

// File: rtl/vend_fsm_param_coin_value.sv
// Combinational decode of a coin code into its credit value.
module vend_coin_value
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 4,
   parameter int COIN_A   = 1,
   parameter int COIN_B   = 3,
   parameter int COIN_C   = 5
) (
   input  coin_t               coin,
   output logic [CREDIT_W-1:0] val
);

   // Parameter names shadow the enum labels, so the labels are package-qualified.
   always_comb begin
      val = '0;
      case (coin)
         vend_pkg::COIN_A: val = CREDIT_W'(COIN_A);
         vend_pkg::COIN_B: val = CREDIT_W'(COIN_B);
         vend_pkg::COIN_C: val = CREDIT_W'(COIN_C);
         default:          val = '0;
      endcase
   end

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised coin-operated vending controller with overflow coin rejection.
// Refund path is built only when VEND_REFUND_EN is defined.
//
// state  | meaning
// IDLE   | credit is 0, no pulse
// HOLD   | credit > 0, no pulse
// VEND   | drop pulses this cycle
// REFUND | change_valid pulses this cycle (wins over VEND)
module vend_fsm_param
   import vend_pkg::*;
#(
   parameter int PRICE    = 4,
   parameter int CREDIT_W = 4,
   parameter int COIN_A   = 1,
   parameter int COIN_B   = 3,
   parameter int COIN_C   = 5
) (
   input logic              clock,
   input logic              reset,
   vend_fsm_param_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_HOLD   = 2'(HOLD);
   localparam logic [1:0] ST_VEND   = 2'(VEND);
   localparam logic [1:0] ST_REFUND = 2'(REFUND);

   localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);

   logic [CREDIT_W-1:0] credit_q, change_amt_q;
   logic                drop_q, change_valid_q, coin_reject_q;
   logic [1:0]          state_q;

   logic [CREDIT_W-1:0] val;
   logic [CREDIT_W:0]   sum_raw, sum_kept;
   logic [CREDIT_W-1:0] sum_vended, credit_n, change_amt_n;
   logic                reject_n, drop_n, refund_n;
   logic [1:0]          state_n;

   vend_coin_value #(
      .CREDIT_W (CREDIT_W),
      .COIN_A   (COIN_A),
      .COIN_B   (COIN_B),
      .COIN_C   (COIN_C)
   ) u_coin_value (
      .coin (coin_t'(bus.coin)),
      .val  (val)
   );

`ifdef VEND_REFUND_EN
   assign refund_n = bus.refund_req;
`else
   logic unused_refund_req;
   assign unused_refund_req = bus.refund_req;
   assign refund_n = 1'b0;
`endif

   always_comb begin
      sum_raw  = {1'b0, credit_q} + {1'b0, val};
      reject_n = sum_raw[CREDIT_W];
      sum_kept = reject_n ? {1'b0, credit_q} : sum_raw;
      drop_n   = (sum_kept >= PRICE_W);
      // After an accepted coin the top bit is clear, so truncation is lossless.
      sum_vended   = drop_n ? CREDIT_W'(sum_kept - PRICE_W) : CREDIT_W'(sum_kept);
      credit_n     = refund_n ? '0 : sum_vended;
      change_amt_n = refund_n ? sum_vended : '0;

      if (refund_n)
         state_n = ST_REFUND;
      else if (drop_n)
         state_n = ST_VEND;
      else if (credit_n != '0)
         state_n = ST_HOLD;
      else
         state_n = ST_IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         credit_q       <= '0;
         drop_q         <= 1'b0;
         change_valid_q <= 1'b0;
         change_amt_q   <= '0;
         coin_reject_q  <= 1'b0;
         state_q        <= ST_IDLE;
      end else begin
         credit_q       <= credit_n;
         drop_q         <= drop_n;
         change_valid_q <= refund_n;
         change_amt_q   <= change_amt_n;
         coin_reject_q  <= reject_n;
         state_q        <= state_n;
      end
   end

   assign bus.credit       = credit_q;
   assign bus.drop         = drop_q;
   assign bus.change_valid = change_valid_q;
   assign bus.change_amt   = change_amt_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param with default parameters; honours VEND_REFUND_EN.
module tb_vend_fsm_param;

`ifdef VEND_REFUND_EN
   localparam bit REF = 1'b1;
`else
   localparam bit REF = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0, S_HOLD = 2'd1, S_VEND = 2'd2, S_REF = 2'd3;

   typedef struct {
      int         idx;
      logic       drop;
      int         credit;
      logic       cv;
      int         camt;
      logic       rej;
      logic [1:0] st;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_step = 0;

   always #5 clock = ~clock;

   vend_fsm_param_if #(.CREDIT_W(4)) bus ();

   vend_fsm_param #(
      .PRICE(4), .CREDIT_W(4), .COIN_A(1), .COIN_B(3), .COIN_C(5)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input int idx, input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step%0d %s: got %0d, expected %0d", idx, name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic step(input logic r, input logic [1:0] c, input logic rf,
                       input logic d, input int cr, input logic cv, input int ca,
                       input logic rj, input logic [1:0] st);
      exp_t e;
      @(negedge clock);
      reset          = r;
      bus.coin       = c;
      bus.refund_req = rf;
      e.idx = n_step; e.drop = d; e.credit = cr; e.cv = cv;
      e.camt = ca; e.rej = rj; e.st = st;
      q.push_back(e);
      n_step++;
   endtask

   always @(posedge clock) begin
      exp_t e;
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk(e.idx, "drop",         int'(bus.drop),         int'(e.drop));
         chk(e.idx, "credit",       int'(bus.credit),       e.credit);
         chk(e.idx, "change_valid", int'(bus.change_valid), int'(e.cv));
         chk(e.idx, "change_amt",   int'(bus.change_amt),   e.camt);
         chk(e.idx, "coin_reject",  int'(bus.coin_reject),  int'(e.rej));
         chk(e.idx, "state",        int'(bus.state),        int'(e.st));
      end
   end

   initial begin
      reset = 1'b1;
      bus.coin = 2'b00;
      bus.refund_req = 1'b0;

      // reset state
      step(1, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE);
      step(1, 2'b11, 1, 0, 0, 0, 0, 0, S_IDLE);

      // 1: four A coins
      step(0, 2'b01, 0, 0, 1, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 2, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 3, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 1, 0, 0, 0, 0, S_VEND);
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE);

      // 2: credit 3 + C vends twice
      step(0, 2'b01, 0, 0, 1, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 2, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 3, 0, 0, 0, S_HOLD);
      step(0, 2'b11, 0, 1, 4, 0, 0, 0, S_VEND);
      step(0, 2'b00, 0, 1, 0, 0, 0, 0, S_VEND);
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE);

      // 3: refund of credit 2
      step(0, 2'b01, 0, 0, 1, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 2, 0, 0, 0, S_HOLD);
      step(0, 2'b00, 1, 0, REF ? 0 : 2, REF, REF ? 2 : 0, 0, REF ? S_REF : S_HOLD);
      step(0, 2'b00, 0, 0, REF ? 0 : 2, 0, 0, 0, REF ? S_IDLE : S_HOLD);
      step(1, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE);

      // refund with zero credit
      step(0, 2'b00, 1, 0, 0, REF, 0, 0, REF ? S_REF : S_IDLE);
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE);

      // 4: each C coin nets +1 credit after a vend, up to 11, then overflow
      for (int i = 1; i <= 11; i++)
         step(0, 2'b11, 0, 1, i, 0, 0, 0, S_VEND);
      step(0, 2'b11, 0, 1, 7, 0, 0, 1, S_VEND);
      step(0, 2'b00, 0, 1, 3, 0, 0, 0, S_VEND);
      step(0, 2'b00, 0, 0, 3, 0, 0, 0, S_HOLD);
      step(1, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE);

      // 5: credit 3 + B with refund: vend and refund together
      step(0, 2'b01, 0, 0, 1, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 2, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 3, 0, 0, 0, S_HOLD);
      step(0, 2'b10, 1, 1, REF ? 0 : 2, REF, REF ? 2 : 0, 0, REF ? S_REF : S_VEND);
      step(0, 2'b00, 0, 0, REF ? 0 : 2, 0, 0, 0, REF ? S_IDLE : S_HOLD);
      step(1, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE);

      // 6: reset mid-vend discards the coin
      step(0, 2'b01, 0, 0, 1, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 2, 0, 0, 0, S_HOLD);
      step(0, 2'b01, 0, 0, 3, 0, 0, 0, S_HOLD);
      step(0, 2'b11, 0, 1, 4, 0, 0, 0, S_VEND);
      step(1, 2'b11, 0, 0, 0, 0, 0, 0, S_IDLE);
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE);

      // reset mid-refund
      step(0, 2'b10, 0, 0, 3, 0, 0, 0, S_HOLD);
      step(0, 2'b00, 1, 0, REF ? 0 : 3, REF, REF ? 3 : 0, 0, REF ? S_REF : S_HOLD);
      step(1, 2'b00, 1, 0, 0, 0, 0, 0, S_IDLE);

      begin : drain
         int budget = 20;
         while (q.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
         end
         @(negedge clock);
         checks++;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
